// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch / PC stage.
package fetch_pkg;

    // Fetch sequencing: idle, request out, awaiting response, holding for decode.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam int          PC_W_DEF     = 8;
    localparam int          INSN_W_DEF   = 8;
    localparam int          NPC_W_DEF    = 16;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

endpackage

// File: rtl/fetch_out_reg.sv
// Decode-side output register: holds one fetched instruction until decode
// takes it, and counts every instruction decode accepts.
module fetch_out_reg
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INSN_W = INSN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [INSN_W-1:0] load_insn,
    input  logic [PC_W-1:0]   load_pc,
    output logic              valid,
    output logic [INSN_W-1:0] insn,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       insn_cnt
);

    // Load wins, then handshake (consumes and counts even if a flush coincides), then flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            insn     <= '0;
            pc       <= '0;
            insn_cnt <= '0;
        end else if (load) begin
            valid <= 1'b1;
            insn  <= load_insn;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid    <= 1'b0;
            insn_cnt <= insn_cnt + 16'd1;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_pc.sv
// PC register and fetch sequencer: issues one memory request per instruction,
// hands the response to the next-PC stage and to decode, and handles redirects.
module instr_fetch_pc
    import fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSN_W   = INSN_W_DEF,
    parameter int              NPC_W    = NPC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    output logic [INSN_W-1:0] npc_insn,
    output logic [PC_W-1:0]   npc_pc,
    input  logic [NPC_W-1:0]  npc_next,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [INSN_W-1:0] dec_insn,
    output logic [PC_W-1:0]   dec_pc,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       insn_cnt
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            redir_pend, pend_nxt;
    logic [PC_W-1:0] redir_tgt, tgt_nxt;
    logic            load, flush, hs, squash;

    // Upper next-PC bits are dropped on purpose so the PC wraps.
    logic npc_unused;
    assign npc_unused = ^npc_next[NPC_W-1:PC_W];

    assign imem_req_addr = pc;
    assign npc_insn      = imem_rsp_data;
    assign npc_pc        = pc;
    assign hs            = dec_valid && dec_ready;
    // A response is dropped if a redirect is pending or arrives alongside it.
    assign squash        = redir_pend || redirect_valid;

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            redir_pend <= pend_nxt;
            redir_tgt  <= tgt_nxt;
        end
    end

    // Next-state, PC update and request/decode-register control.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_nxt       = redir_pend;
        tgt_nxt        = redir_tgt;
        load           = 1'b0;
        flush          = 1'b0;
        imem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) pc_nxt = redirect_pc;
                if (en) state_nxt = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (redirect_valid) begin
                    pend_nxt = 1'b1;
                    tgt_nxt  = redirect_pc;
                end
                if (imem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (squash) begin
                        pc_nxt    = redirect_valid ? redirect_pc : redir_tgt;
                        pend_nxt  = 1'b0;
                        state_nxt = en ? REQ : IDLE;
                    end else begin
                        load      = 1'b1;
                        pc_nxt    = npc_next[PC_W-1:0];
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    pend_nxt = 1'b1;
                    tgt_nxt  = redirect_pc;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    flush  = !hs;
                end
                if (hs || redirect_valid) state_nxt = en ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    fetch_out_reg #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .flush     (flush),
        .ready     (dec_ready),
        .load_insn (imem_rsp_data),
        .load_pc   (pc),
        .valid     (dec_valid),
        .insn      (dec_insn),
        .pc        (dec_pc),
        .insn_cnt  (insn_cnt)
    );

endmodule

// File: tb/tb_instr_fetch_pc.sv
// Directed bench: memory model with programmable latency, next-PC stub = pc+2.
module tb_instr_fetch_pc;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        imem_req_valid, imem_req_ready;
    logic [7:0]  imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [7:0]  imem_rsp_data  = 8'h00;
    logic [7:0]  npc_insn, npc_pc;
    logic [15:0] npc_next;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        dec_valid, dec_ready;
    logic [7:0]  dec_insn, dec_pc, pc;
    logic [15:0] insn_cnt;

    logic [7:0] mem [256];
    int         mem_lat;
    bit         m_pend = 1'b0;
    int         m_cd   = 0;
    logic [7:0] m_addr = 8'h00;

    int n_pass = 0;
    int n_tot  = 0;
    int exp_cnt;

    typedef struct {
        logic [7:0] start_pc;
        logic [7:0] data;
        logic [7:0] exp_pc;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    assign npc_next = {8'h00, pc} + 16'd2;

    instr_fetch_pc dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .npc_insn(npc_insn), .npc_pc(npc_pc),
        .npc_next(npc_next), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_insn(dec_insn),
        .dec_pc(dec_pc), .pc(pc), .insn_cnt(insn_cnt)
    );

    // Memory: one response per accepted request, mem_lat extra cycles after acceptance.
    always @(posedge clk) begin
        imem_rsp_valid <= 1'b0;
        if (m_pend) begin
            if (m_cd == 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem[m_addr];
                m_pend         <= 1'b0;
            end else begin
                m_cd <= m_cd - 1;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            if (mem_lat == 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem[imem_req_addr];
            end else begin
                m_pend <= 1'b1;
                m_cd   <= mem_lat - 1;
                m_addr <= imem_req_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Finish a fetch started from REQ with zero-wait memory and en already low.
    task automatic finish_fetch(input string nm, input logic [7:0] exp_dpc);
        tick();
        tick();
        chk({nm, "_dec_pc"}, {24'h0, dec_pc}, {24'h0, exp_dpc});
        tick();
        exp_cnt++;
        chk({nm, "_cnt"}, {16'h0, insn_cnt}, exp_cnt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        vecs[0] = '{8'h10, 8'hA1, 8'h12};
        vecs[1] = '{8'hFE, 8'h3C, 8'h00};
        vecs[2] = '{8'hFF, 8'h77, 8'h01};
        vecs[3] = '{8'h7F, 8'h00, 8'h81};
        mem[8'h00] = 8'h45;
        mem[8'h80] = 8'hC3;

        rst = 1'b1; en = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00; mem_lat = 0; exp_cnt = 0;
        tick();
        tick();
        chk("rst_pc", {24'h0, pc}, 32'h00);
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
        chk("rst_dec_insn_pc", {16'h0, dec_insn, dec_pc}, 32'h0);
        chk("rst_cnt", {16'h0, insn_cnt}, 32'h0);

        // First fetch, then decode back-pressure
        rst = 1'b0; en = 1'b1;
        tick();
        chk("f1_req", {23'h0, imem_req_valid, imem_req_addr}, 32'h100);
        tick();
        chk("f1_wait_noval", {31'h0, dec_valid}, 32'h0);
        tick();
        chk("f1_dec", {15'h0, dec_valid, dec_insn, dec_pc}, 32'h1_4500);
        chk("f1_pc", {24'h0, pc}, 32'h02);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {14'h0, dec_valid, imem_req_valid, dec_insn, dec_pc}, 32'h2_4500);
        end
        chk("bp_cnt_before", {16'h0, insn_cnt}, 32'h0);
        dec_ready = 1'b1; en = 1'b0;
        tick();
        exp_cnt = 1;
        chk("bp_cnt_after", {16'h0, insn_cnt}, exp_cnt);
        chk("bp_idle", {30'h0, dec_valid, imem_req_valid}, 32'h0);

        // Table: start PC via idle redirect, fetch, then next request address
        foreach (vecs[v]) begin
            mem[vecs[v].start_pc] = vecs[v].data;
            redirect_valid = 1'b1; redirect_pc = vecs[v].start_pc;
            tick();
            redirect_valid = 1'b0; en = 1'b1;
            tick();
            chk("vec_req", {23'h0, imem_req_valid, imem_req_addr}, {23'h0, 1'b1, vecs[v].start_pc});
            tick();
            tick();
            chk("vec_dec", {7'h0, dec_valid, dec_insn, dec_pc, pc},
                {7'h0, 1'b1, vecs[v].data, vecs[v].start_pc, vecs[v].exp_pc});
            tick();
            chk("vec_next_req", {23'h0, imem_req_valid, imem_req_addr}, {23'h0, 1'b1, vecs[v].exp_pc});
            en = 1'b0;
            exp_cnt++;
            finish_fetch("vec2", vecs[v].exp_pc);
        end

        // Redirect while waiting on a slow response
        en = 1'b1; mem_lat = 2;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        tick();
        redirect_valid = 1'b0;
        chk("rw_noval1", {31'h0, dec_valid}, 32'h0);
        tick();
        chk("rw_noval2", {31'h0, dec_valid}, 32'h0);
        mem_lat = 0;
        tick();
        chk("rw_squash", {22'h0, dec_valid, imem_req_valid, imem_req_addr}, 32'h180);
        chk("rw_cnt", {16'h0, insn_cnt}, exp_cnt);
        en = 1'b0;
        tick();
        tick();
        chk("rw_dec", {16'h0, dec_insn, dec_pc}, 32'hC380);
        tick();
        exp_cnt++;
        chk("rw_cnt2", {16'h0, insn_cnt}, exp_cnt);

        // Redirect in the same cycle as the response
        en = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 8'h20;
        tick();
        redirect_valid = 1'b0;
        chk("rsame", {22'h0, dec_valid, imem_req_valid, imem_req_addr}, 32'h120);
        en = 1'b0;
        finish_fetch("rsame2", 8'h20);

        // Redirect in HOLD with simultaneous decode handshake
        en = 1'b1;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect_valid = 1'b0;
        exp_cnt++;
        chk("rhs_cnt", {16'h0, insn_cnt}, exp_cnt);
        chk("rhs_req", {22'h0, dec_valid, imem_req_valid, imem_req_addr}, 32'h140);
        en = 1'b0;
        finish_fetch("rhs2", 8'h40);

        // Redirect in HOLD without handshake flushes the instruction
        en = 1'b1;
        tick();
        tick();
        dec_ready = 1'b0;
        tick();
        chk("rfl_hold", {31'h0, dec_valid}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 8'h60; en = 1'b0;
        tick();
        redirect_valid = 1'b0; dec_ready = 1'b1;
        chk("rfl_flush", {14'h0, dec_valid, imem_req_valid, pc, insn_cnt[7:0]},
            {14'h0, 2'b00, 8'h60, 8'(exp_cnt)});

        // Memory not ready: request held stable
        imem_req_ready = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", {23'h0, imem_req_valid, imem_req_addr}, 32'h160);
        end
        imem_req_ready = 1'b1;
        finish_fetch("stall2", 8'h60);

        // Reset during WAIT; late response must be ignored
        en = 1'b1; mem_lat = 1;
        tick();
        tick();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rstw", {6'h0, dec_valid, imem_req_valid, pc, insn_cnt}, 32'h0);
        chk("rstw_dec", {16'h0, dec_insn, dec_pc}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
